tl_ram_bytemask: RTL and testbench

- Parametrised byte-addressed single-clock RAM that backs the TileLink slave data path; successor to the fixed 64-bit / 1 KiB RAM.
- Adds configurable data width, depth and read latency, per-byte write mask, a read-valid strobe, and range/alignment error reporting.
- One write port and one read port, usable in the same cycle; the read pipeline accepts one read per cycle.

---
 rtl/tl_ram_bytemask.sv | 116 +++++++++++
 tb/tb_tl_ram_bytemask.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_bytemask.sv
// Byte-addressed single-clock RAM behind the TileLink slave data path.
// Per-lane write mask, configurable read latency, and range/alignment error flags.
module tl_ram_bytemask #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wen,
  input  logic [ADDR_W-1:0]     i_write_address,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [DATA_W/8-1:0]   i_wmask,
  input  logic                  i_ren,
  input  logic [ADDR_W-1:0]     i_read_address,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_rvalid,
  output logic                  o_rerr,
  output logic                  o_werr
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH_BYTES);

  // The end address is formed one bit wider so addresses near the top of the
  // address space cannot wrap around into the legal range.
  function automatic logic is_legal(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] top;
    logic            aligned;
    top     = {1'b0, addr} + (ADDR_W+1)'(BYTES);
    aligned = (ALIGN_CHECK == 0) || ((addr & ADDR_W'(BYTES - 1)) == '0);
    return (top <= (ADDR_W+1)'(DEPTH_BYTES)) && aligned;
  endfunction

  logic [7:0]        mem [DEPTH_BYTES] = '{default: 8'h00};
  logic              wlegal;
  logic              rlegal;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] rd_word;

  logic              vld_p1;
  logic              err_p1;
  logic [DATA_W-1:0] data_p1;
  logic              werr_p1;

  assign wlegal = is_legal(i_write_address);
  assign rlegal = is_legal(i_read_address);
  assign widx   = i_write_address[IDX_W-1:0];
  assign ridx   = i_read_address[IDX_W-1:0];

  // Storage is not reset; a write seen while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (!rst && i_wen && wlegal) begin
      for (int k = 0; k < BYTES; k++) begin
        if (i_wmask[k]) mem[widx + IDX_W'(k)] <= i_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BYTES; k++) begin
      rd_word[8*k +: 8] = mem[ridx + IDX_W'(k)];
    end
  end

  // Stage p1: array sampled before this edge's write lands, giving read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      data_p1 <= '0;
      werr_p1 <= 1'b0;
    end else begin
      vld_p1  <= i_ren;
      err_p1  <= i_ren && !rlegal;
      data_p1 <= (i_ren && rlegal) ? rd_word : '0;
      werr_p1 <= i_wen && !wlegal;
    end
  end

  assign o_werr = werr_p1;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              vld_p2;
      logic              err_p2;
      logic [DATA_W-1:0] data_p2;

      // Stage p2: plain retiming register of stage p1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p2  <= 1'b0;
          err_p2  <= 1'b0;
          data_p2 <= '0;
        end else begin
          vld_p2  <= vld_p1;
          err_p2  <= err_p1;
          data_p2 <= data_p1;
        end
      end

      assign o_rvalid = vld_p2;
      assign o_rerr   = err_p2;
      assign o_data   = data_p2;
    end else begin : g_lat1
      assign o_rvalid = vld_p1;
      assign o_rerr   = err_p1;
      assign o_data   = data_p1;
    end
  endgenerate

endmodule

// File: tb/tb_tl_ram_bytemask.sv
// Directed bench: instance a has READ_LAT=1/ALIGN_CHECK=1, instance b has READ_LAT=2/ALIGN_CHECK=0.
module tb_tl_ram_bytemask;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        wen_a = 0, ren_a = 0;
  logic [31:0] waddr_a = 0, raddr_a = 0;
  logic [63:0] wdata_a = 0;
  logic [7:0]  wmask_a = 0;
  logic [63:0] rdata_a;
  logic        rvalid_a, rerr_a, werr_a;

  logic        wen_b = 0, ren_b = 0;
  logic [31:0] waddr_b = 0, raddr_b = 0;
  logic [63:0] wdata_b = 0;
  logic [7:0]  wmask_b = 0;
  logic [63:0] rdata_b;
  logic        rvalid_b, rerr_b, werr_b;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] A0 = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] A1 = 64'h1716151413121110;
  localparam logic [63:0] A2 = 64'h1F1E1D1C1B1A1918;

  always #5 clk = ~clk;

  tl_ram_bytemask #(.DATA_W(64), .DEPTH_BYTES(1024), .ADDR_W(32), .READ_LAT(1), .ALIGN_CHECK(1)) dut_a (
    .clk(clk), .rst(rst),
    .i_wen(wen_a), .i_write_address(waddr_a), .i_data(wdata_a), .i_wmask(wmask_a),
    .i_ren(ren_a), .i_read_address(raddr_a),
    .o_data(rdata_a), .o_rvalid(rvalid_a), .o_rerr(rerr_a), .o_werr(werr_a)
  );

  tl_ram_bytemask #(.DATA_W(64), .DEPTH_BYTES(1024), .ADDR_W(32), .READ_LAT(2), .ALIGN_CHECK(0)) dut_b (
    .clk(clk), .rst(rst),
    .i_wen(wen_b), .i_write_address(waddr_b), .i_data(wdata_b), .i_wmask(wmask_b),
    .i_ren(ren_b), .i_read_address(raddr_b),
    .o_data(rdata_b), .o_rvalid(rvalid_b), .o_rerr(rerr_b), .o_werr(werr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [31:0] addr, input logic [63:0] data,
                         input logic [7:0] mask, output logic werr_seen);
    wen_a = 1; waddr_a = addr; wdata_a = data; wmask_a = mask;
    tick();
    wen_a = 0;
    werr_seen = werr_a;
  endtask

  task automatic write_b(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask);
    wen_b = 1; waddr_b = addr; wdata_b = data; wmask_b = mask;
    tick();
    wen_b = 0;
  endtask

  task automatic read_a(input logic [31:0] addr, output logic [63:0] d,
                        output logic v, output logic e);
    ren_a = 1; raddr_a = addr;
    tick();
    ren_a = 0;
    d = rdata_a; v = rvalid_a; e = rerr_a;
  endtask

  task automatic read_b(input logic [31:0] addr, output logic [63:0] d,
                        output logic v, output logic e);
    ren_b = 1; raddr_b = addr;
    tick();
    ren_b = 0;
    tick();
    d = rdata_b; v = rvalid_b; e = rerr_b;
  endtask

  task automatic test_reset();
    ren_a = 1; raddr_a = 32'h10;
    ren_b = 1; raddr_b = 32'h10;
    tick();
    tick();
    total++; if (rdata_a !== 64'h0) begin bad++; $display("FAIL reset_data_a got=%h want=0", rdata_a); end
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL reset_rvalid_a got=%b want=0", rvalid_a); end
    total++; if (rerr_a !== 1'b0) begin bad++; $display("FAIL reset_rerr_a got=%b want=0", rerr_a); end
    total++; if (werr_a !== 1'b0) begin bad++; $display("FAIL reset_werr_a got=%b want=0", werr_a); end
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL reset_rvalid_b got=%b want=0", rvalid_b); end
    ren_a = 0; ren_b = 0;
    rst = 0;
    tick();
  endtask

  task automatic test_masked_write();
    logic [63:0] d; logic v, e, we;
    write_a(32'h10, 64'h1122334455667788, 8'hFF, we);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mw_werr got=%b want=0", we); end
    write_a(32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, we);
    read_a(32'h10, d, v, e);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL mw_rvalid got=%b want=1", v); end
    total++; if (d !== 64'h11223344AAAAAAAA) begin bad++; $display("FAIL mw_data got=%h want=11223344aaaaaaaa", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mw_rerr got=%b want=0", e); end
    tick();
    total++; if (rvalid_a !== 1'b0 || rdata_a !== 64'h0) begin bad++; $display("FAIL mw_idle got=%b/%h want=0/0", rvalid_a, rdata_a); end
    write_a(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, we);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mw_zero_mask_werr got=%b want=0", we); end
    read_a(32'h10, d, v, e);
    total++; if (d !== 64'h11223344AAAAAAAA) begin bad++; $display("FAIL mw_zero_mask_data got=%h want=11223344aaaaaaaa", d); end
  endtask

  task automatic test_back_to_back();
    write_b(32'h00, A0, 8'hFF);
    write_b(32'h08, A1, 8'hFF);
    write_b(32'h10, A2, 8'hFF);
    ren_b = 1; raddr_b = 32'h00;
    tick();
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b want=0", rvalid_b); end
    raddr_b = 32'h08;
    tick();
    total++; if (rvalid_b !== 1'b1 || rdata_b !== A0) begin bad++; $display("FAIL b2b_0 got=%b/%h want=1/%h", rvalid_b, rdata_b, A0); end
    raddr_b = 32'h10;
    tick();
    total++; if (rvalid_b !== 1'b1 || rdata_b !== A1) begin bad++; $display("FAIL b2b_1 got=%b/%h want=1/%h", rvalid_b, rdata_b, A1); end
    ren_b = 0;
    tick();
    total++; if (rvalid_b !== 1'b1 || rdata_b !== A2) begin bad++; $display("FAIL b2b_2 got=%b/%h want=1/%h", rvalid_b, rdata_b, A2); end
    tick();
    total++; if (rvalid_b !== 1'b0 || rdata_b !== 64'h0 || rerr_b !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b/%h/%b want=0/0/0", rvalid_b, rdata_b, rerr_b); end
  endtask

  task automatic test_rw_same_cycle();
    wen_a = 1; waddr_a = 32'h20; wdata_a = 64'hDEADBEEFCAFEF00D; wmask_a = 8'hFF;
    ren_a = 1; raddr_a = 32'h20;
    tick();
    wen_a = 0;
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 64'h0) begin bad++; $display("FAIL rw_old got=%b/%h want=1/0", rvalid_a, rdata_a); end
    tick();
    ren_a = 0;
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL rw_new got=%b/%h want=1/deadbeefcafef00d", rvalid_a, rdata_a); end
  endtask

  task automatic test_errors();
    logic [63:0] d; logic v, e, we;
    write_a(32'h3F8, 64'hCAFE000012345678, 8'hFF, we);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL err_legal_werr got=%b want=0", we); end
    write_a(32'h3FC, 64'hFFFFFFFFFFFFFFFF, 8'hFF, we);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL err_3fc_werr got=%b want=1", we); end
    tick();
    total++; if (werr_a !== 1'b0) begin bad++; $display("FAIL err_werr_pulse got=%b want=0", werr_a); end
    read_a(32'h3F8, d, v, e);
    total++; if (v !== 1'b1 || e !== 1'b0 || d !== 64'hCAFE000012345678) begin bad++; $display("FAIL err_3f8 got=%b/%b/%h want=1/0/cafe000012345678", v, e, d); end
    read_a(32'h400, d, v, e);
    total++; if (v !== 1'b1 || e !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL err_400 got=%b/%b/%h want=1/1/0", v, e, d); end
    read_a(32'hFFFFFFF8, d, v, e);
    total++; if (v !== 1'b1 || e !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL err_wrap got=%b/%b/%h want=1/1/0", v, e, d); end
    read_a(32'h04, d, v, e);
    total++; if (v !== 1'b1 || e !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL err_misalign got=%b/%b/%h want=1/1/0", v, e, d); end
    write_a(32'hFFFFFFF8, 64'h1, 8'hFF, we);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL err_wrap_werr got=%b want=1", we); end
  endtask

  task automatic test_unaligned();
    logic [63:0] d; logic v, e;
    write_b(32'h03, 64'h0102030405060708, 8'hFF);
    read_b(32'h03, d, v, e);
    total++; if (v !== 1'b1 || e !== 1'b0 || d !== 64'h0102030405060708) begin bad++; $display("FAIL ua_03 got=%b/%b/%h want=1/0/0102030405060708", v, e, d); end
    read_b(32'h00, d, v, e);
    total++; if (d !== 64'h04050607080A0908) begin bad++; $display("FAIL ua_00 got=%h want=04050607080a0908", d); end
    read_b(32'h08, d, v, e);
    total++; if (d !== 64'h1716151413010203) begin bad++; $display("FAIL ua_08 got=%h want=1716151413010203", d); end
    read_b(32'h3F9, d, v, e);
    total++; if (v !== 1'b1 || e !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL ua_3f9 got=%b/%b/%h want=1/1/0", v, e, d); end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] d; logic v, e, we;
    write_a(32'h30, 64'h5555AAAA12348765, 8'hFF, we);
    ren_a = 1; raddr_a = 32'h30;
    wen_a = 1; waddr_a = 32'h3FC; wdata_a = 64'h0; wmask_a = 8'hFF;
    ren_b = 1; raddr_b = 32'h00;
    tick();
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 64'h5555AAAA12348765 || werr_a !== 1'b1) begin bad++; $display("FAIL rmr_pre got=%b/%h/%b want=1/5555aaaa12348765/1", rvalid_a, rdata_a, werr_a); end
    rst = 1;
    #1;
    total++; if (rvalid_a !== 1'b0 || rdata_a !== 64'h0 || rerr_a !== 1'b0 || werr_a !== 1'b0) begin bad++; $display("FAIL rmr_async got=%b/%h/%b/%b want=0/0/0/0", rvalid_a, rdata_a, rerr_a, werr_a); end
    waddr_a = 32'h30; wdata_a = 64'hFFFFFFFFFFFFFFFF;
    tick();
    wen_a = 0; ren_a = 0; ren_b = 0;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL rmr_post%0d got=%b/%b want=0/0", i, rvalid_a, rvalid_b); end
    end
    read_a(32'h30, d, v, e);
    total++; if (v !== 1'b1 || d !== 64'h5555AAAA12348765) begin bad++; $display("FAIL rmr_retain got=%b/%h want=1/5555aaaa12348765", v, d); end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_back_to_back();
    test_rw_same_cycle();
    test_errors();
    test_unaligned();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
